motion_estimation_fs: RTL and testbench

MOTION_ESTIMATION_FS -- requirements
Module: motion_estimation_fs

---
 rtl/me_pkg.sv | 21 ++
 rtl/sad_row.sv | 28 ++
 rtl/motion_estimation_fs.sv | 129 ++++++++++++
 tb/tb_motion_estimation_fs.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared types and size helpers for the full-search motion estimator.
package me_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_DONE   = 2'd2
   } me_state_t;

   // Motion vector component, also consumed by motion compensation.
   typedef logic [5:0] mv_t;

   function automatic int sad_width(input int mb, input int pw);
      return pw + $clog2(mb * mb);
   endfunction

   function automatic int num_cand(input int rf, input int mb);
      return (rf - mb + 1) * (rf - mb + 1);
   endfunction

endpackage

// File: rtl/sad_row.sv
// Combinational sum of absolute differences across one block row.
module sad_row #(
   parameter int MB_SIZE     = 4,
   parameter int PIXEL_WIDTH = 8,
   parameter int SAD_W       = 12
) (
   input  logic [MB_SIZE-1:0][PIXEL_WIDTH-1:0] i_curr,
   input  logic [MB_SIZE-1:0][PIXEL_WIDTH-1:0] i_ref,
   output logic [SAD_W-1:0]                    o_sad
);

   logic [MB_SIZE-1:0][PIXEL_WIDTH-1:0] w_diff;

   generate
      for (genvar gi = 0; gi < MB_SIZE; gi++) begin : g_diff
         assign w_diff[gi] = (i_curr[gi] > i_ref[gi]) ? (i_curr[gi] - i_ref[gi])
                                                      : (i_ref[gi] - i_curr[gi]);
      end
   endgenerate

   always_comb begin
      o_sad = '0;
      for (int i = 0; i < MB_SIZE; i++) begin
         o_sad = o_sad + SAD_W'(w_diff[i]);
      end
   end

endmodule

// File: rtl/motion_estimation_fs.sv
// Full-search block motion estimator, one candidate row per cycle.
// Optional feature: define ME_EARLY_TERM_EN to abandon hopeless candidates early.
module motion_estimation_fs
   import me_pkg::*;
#(
   parameter  int MB_SIZE        = 4,
   parameter  int PIXEL_WIDTH    = 8,
   parameter  int REF_FRAME_SIZE = 8,
   localparam int SAD_W          = sad_width(MB_SIZE, PIXEL_WIDTH)
) (
   input  logic                                                          clk,
   input  logic                                                          reset,
   input  logic                                                          start,
   input  logic [REF_FRAME_SIZE-1:0][REF_FRAME_SIZE-1:0][PIXEL_WIDTH-1:0] ref_frame,
   input  logic [MB_SIZE-1:0][MB_SIZE-1:0][PIXEL_WIDTH-1:0]               curr_mb,
   output logic                                                          busy,
   output logic                                                          done,
   output mv_t                                                           mv_x,
   output mv_t                                                           mv_y,
   output logic [SAD_W-1:0]                                              min_sad
);

   localparam int MAX_OFF = REF_FRAME_SIZE - MB_SIZE;
   localparam int RW      = (MB_SIZE > 1) ? $clog2(MB_SIZE) : 1;
   localparam int FW      = (REF_FRAME_SIZE > 1) ? $clog2(REF_FRAME_SIZE) : 1;

   me_state_t          r_state;
   mv_t                r_cx, r_cy, r_best_x, r_best_y, r_mv_x, r_mv_y;
   logic [RW-1:0]      r_row;
   logic [SAD_W-1:0]   r_acc, r_best_sad, r_min_sad;

   logic [FW-1:0]                       w_ref_r;
   logic [MB_SIZE-1:0][PIXEL_WIDTH-1:0] w_ref_pix;
   logic [SAD_W-1:0]                    w_row_sad, w_cand_sad;
   logic w_last_row, w_last_x, w_last_cand, w_take, w_abandon, w_enter;

   assign w_ref_r = FW'(r_cy) + FW'(r_row);

   generate
      for (genvar gi = 0; gi < MB_SIZE; gi++) begin : g_ref
         logic [FW-1:0] w_ref_c;
         assign w_ref_c       = FW'(r_cx) + FW'(gi);
         assign w_ref_pix[gi] = ref_frame[w_ref_r][w_ref_c];
      end
   endgenerate

   sad_row #(
      .MB_SIZE     (MB_SIZE),
      .PIXEL_WIDTH (PIXEL_WIDTH),
      .SAD_W       (SAD_W)
   ) u_sad_row (
      .i_curr (curr_mb[r_row]),
      .i_ref  (w_ref_pix),
      .o_sad  (w_row_sad)
   );

   assign w_cand_sad  = r_acc + w_row_sad;
   assign w_last_row  = (r_row == RW'(MB_SIZE - 1));
   assign w_last_x    = (r_cx == mv_t'(MAX_OFF));
   assign w_last_cand = w_last_x && (r_cy == mv_t'(MAX_OFF));
   // Strict compare keeps the earliest candidate on ties.
   assign w_take      = w_last_row && (w_cand_sad < r_best_sad);
   assign w_enter     = start && (r_state != ST_SEARCH);

`ifdef ME_EARLY_TERM_EN
   // A partial already at the best can never win strictly, so skip the rest.
   assign w_abandon = !w_last_row && (w_cand_sad >= r_best_sad);
`else
   assign w_abandon = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_cx       <= '0;
         r_cy       <= '0;
         r_row      <= '0;
         r_acc      <= '0;
         r_best_sad <= '0;
         r_best_x   <= '0;
         r_best_y   <= '0;
         r_mv_x     <= '0;
         r_mv_y     <= '0;
         r_min_sad  <= '0;
      end else if (w_enter) begin
         r_state    <= ST_SEARCH;
         r_cx       <= '0;
         r_cy       <= '0;
         r_row      <= '0;
         r_acc      <= '0;
         r_best_sad <= '1;
         r_best_x   <= '0;
         r_best_y   <= '0;
      end else if (r_state == ST_SEARCH) begin
         if (w_last_row || w_abandon) begin
            r_acc <= '0;
            r_row <= '0;
            if (w_take) begin
               r_best_sad <= w_cand_sad;
               r_best_x   <= r_cx;
               r_best_y   <= r_cy;
            end
            if (w_last_cand) begin
               r_state   <= ST_DONE;
               r_mv_x    <= w_take ? r_cx : r_best_x;
               r_mv_y    <= w_take ? r_cy : r_best_y;
               r_min_sad <= w_take ? w_cand_sad : r_best_sad;
            end else if (w_last_x) begin
               r_cx <= '0;
               r_cy <= r_cy + 6'd1;
            end else begin
               r_cx <= r_cx + 6'd1;
            end
         end else begin
            r_acc <= w_cand_sad;
            r_row <= r_row + RW'(1);
         end
      end else begin
         r_state <= ST_IDLE;
      end
   end

   assign busy    = (r_state == ST_SEARCH);
   assign done    = (r_state == ST_DONE);
   assign mv_x    = r_mv_x;
   assign mv_y    = r_mv_y;
   assign min_sad = r_min_sad;

endmodule

// File: tb/tb_motion_estimation_fs.sv
// Scoreboard bench for motion_estimation_fs: directed searches with hand-computed results.
module tb_motion_estimation_fs;

   logic                       clk = 1'b0;
   logic                       reset = 1'b1;
   logic                       start = 1'b0;
   logic [7:0][7:0][7:0]       ref_frame;
   logic [3:0][3:0][7:0]       curr_mb;
   logic                       busy, done;
   logic [5:0]                 mv_x, mv_y;
   logic [11:0]                min_sad;

   typedef struct {
      int x;
      int y;
      int sad;
      int t0;
      bit early;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   t_issue = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   motion_estimation_fs #(
      .MB_SIZE        (4),
      .PIXEL_WIDTH    (8),
      .REF_FRAME_SIZE (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .ref_frame (ref_frame),
      .curr_mb   (curr_mb),
      .busy      (busy),
      .done      (done),
      .mv_x      (mv_x),
      .mv_y      (mv_y),
      .min_sad   (min_sad)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   task automatic set_ramp();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            ref_frame[r][c] = 8'(16 * r + c);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            curr_mb[i][j] = ref_frame[i + 3][j + 2];
   endtask

   task automatic set_flat(input logic [7:0] rv, input logic [7:0] cv);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            ref_frame[r][c] = rv;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            curr_mb[i][j] = cv;
   endtask

   task automatic issue(input int x, input int y, input int sad, input bit early);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      t_issue = cyc;
      e.x = x; e.y = y; e.sad = sad; e.t0 = t_issue; e.early = early;
      sb.push_back(e);
      $display("issue search: expect mv=(%0d,%0d) sad=%0d", x, y, sad);
   endtask

   task automatic wait_cyc(input int target);
      int n = 0;
      while (cyc < target && n < 1000) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_results(input int settle);
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
         sb.delete();
      end
      repeat (settle) @(negedge clk);
   endtask

   initial begin
      set_ramp();

      fork
         forever begin
            @(negedge clk);
            if (!reset && done) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
               end else begin
                  exp_t e;
                  int   lat;
                  e   = sb.pop_front();
                  lat = cyc - e.t0;
                  chk("mv_x", int'(mv_x), e.x);
                  chk("mv_y", int'(mv_y), e.y);
                  chk("min_sad", int'(min_sad), e.sad);
`ifdef ME_EARLY_TERM_EN
                  if (e.early) chk("latency_below_100", int'(lat < 100), 1);
                  else         chk("latency_at_most_100", int'(lat <= 100), 1);
`else
                  chk("latency", lat, 100);
`endif
               end
            end
         end
      join_none

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_min_sad", int'(min_sad), 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Ramp window, block lifted from (2,3)
      set_ramp();
      issue(2, 3, 0, 1'b1);
      @(negedge clk);
      chk("busy_in_search", int'(busy), 1);
      wait_results(4);
      chk("idle_after_done", int'(busy), 0);

      // Uniform picture: every candidate ties, earliest wins
      set_flat(8'd50, 8'd50);
      issue(0, 0, 0, 1'b0);
      wait_results(4);

      // Maximum SAD must not wrap
      set_flat(8'd0, 8'd255);
      issue(0, 0, 4080, 1'b0);
      wait_results(4);

      // Reset in the middle of a search
      set_ramp();
      issue(2, 3, 0, 1'b1);
      wait_cyc(t_issue + 40);
      reset = 1'b1;
      #1;
      sb.delete();
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_mv_x", int'(mv_x), 0);
      chk("midrst_mv_y", int'(mv_y), 0);
      chk("midrst_min_sad", int'(min_sad), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      issue(2, 3, 0, 1'b1);
      wait_results(4);

      // start re-pulsed twice during a search must be ignored
      set_flat(8'd0, 8'd255);
      issue(0, 0, 4080, 1'b0);
      wait_cyc(t_issue + 10);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_cyc(t_issue + 50);
      chk("busy_at_50", int'(busy), 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_results(130);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
